// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter sharing one word-wide memory port between the
//           I-cache (requester 0) and D-cache (requester 1); each grant is one
//           full cache-line burst (refill or write-back) run to completion.
// Latency : req sampled in cycle N, mem_req from N+1; done = WORDS + waits + 2.
// Backpressure: mem_ready=0 stalls the burst; all BUSY outputs hold.
// Ports   : req/we/addr/wdata per requester in; word_ack/done per requester out;
//           word_idx, rdata, busy status out; mem_* is the main-memory port.
module mem_arbiter #(
  parameter int LINE_ADDR_LEN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [31:0]              addr0,
  input  logic [31:0]              wdata0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [31:0]              addr1,
  input  logic [31:0]              wdata1,
  output logic                     word_ack0,
  output logic                     word_ack1,
  output logic                     done0,
  output logic                     done1,
  output logic [LINE_ADDR_LEN-1:0] word_idx,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ready
);

  localparam int WORDS = 1 << LINE_ADDR_LEN;
  localparam logic [LINE_ADDR_LEN-1:0] LAST_IDX = LINE_ADDR_LEN'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state, state_nxt;
  logic                     owner, owner_nxt;
  logic                     burst_we, burst_we_nxt;
  logic                     last_grant, last_grant_nxt;
  logic [31:0]              base_addr, base_addr_nxt;
  logic [LINE_ADDR_LEN-1:0] cnt, cnt_nxt;
  logic                     done0_q, done0_nxt;
  logic                     done1_q, done1_nxt;
  logic                     grant;
  logic [31:0]              sel_addr;

  // Line-offset bits of the request addresses are intentionally dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{addr0[LINE_ADDR_LEN+1:0], addr1[LINE_ADDR_LEN+1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      burst_we   <= 1'b0;
      last_grant <= 1'b1;
      base_addr  <= '0;
      cnt        <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      burst_we   <= burst_we_nxt;
      last_grant <= last_grant_nxt;
      base_addr  <= base_addr_nxt;
      cnt        <= cnt_nxt;
      done0_q    <= done0_nxt;
      done1_q    <= done1_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    burst_we_nxt   = burst_we;
    last_grant_nxt = last_grant;
    base_addr_nxt  = base_addr;
    cnt_nxt        = cnt;
    done0_nxt      = 1'b0;
    done1_nxt      = 1'b0;
    // With both pending, the side that did not win last time gets the grant.
    grant          = (req0 && req1) ? ~last_grant : req1;
    sel_addr       = grant ? addr1 : addr0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nxt     = grant;
          burst_we_nxt  = grant ? we1 : we0;
          base_addr_nxt = {sel_addr[31:LINE_ADDR_LEN+2], {(LINE_ADDR_LEN+2){1'b0}}};
          cnt_nxt       = '0;
          state_nxt     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state_nxt      = DONE;
            last_grant_nxt = owner;
            done0_nxt      = ~owner;
            done1_nxt      = owner;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: everything but done is a function of BUSY plus live inputs,
  // so an asynchronous reset clears the memory port in the same cycle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    word_idx  = '0;
    word_ack0 = 1'b0;
    word_ack1 = 1'b0;
    rdata     = '0;
    if (state == BUSY) begin
      mem_req   = 1'b1;
      mem_we    = burst_we;
      // cnt < WORDS, so the offset never carries past the line or into [1:0].
      mem_addr  = base_addr + {{(30-LINE_ADDR_LEN){1'b0}}, cnt, 2'b00};
      mem_wdata = owner ? wdata1 : wdata0;
      word_idx  = cnt;
      rdata     = mem_rdata;
      word_ack0 = mem_ready & ~owner;
      word_ack1 = mem_ready & owner;
    end
  end

  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0, wdata1;
  logic        word_ack0, word_ack1, done0, done1, busy;
  logic [2:0]  word_idx;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_req, mem_we, mem_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;  // 0: mem_ready always 1; 1: high every 3rd cycle

  typedef struct {
    logic        r;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  logic done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] wd(input logic r, input logic [2:0] i);
    return (r ? 32'hD100_0000 : 32'hD000_0000) | {29'd0, i};
  endfunction

  // Cache and memory models
  assign wdata0    = wd(1'b0, word_idx);
  assign wdata1    = wd(1'b1, word_idx);
  assign mem_rdata = 32'hA500_0000 ^ mem_addr;
  assign mem_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);

  mem_arbiter #(.LINE_ADDR_LEN(3)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .word_ack0(word_ack0), .word_ack1(word_ack1),
    .done0(done0), .done1(done1),
    .word_idx(word_idx), .rdata(rdata), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Expected burst: hand-computed line base, 8 words in order, one done.
  task automatic push_burst(input logic r, input logic we, input logic [31:0] base);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.r     = r;
      e.we    = we;
      e.addr  = base + 32'(4 * i);
      e.wdata = wd(r, 3'(i));
      exp_q.push_back(e);
    end
    done_q.push_back(r);
  endtask

  // Waits (bounded) for the given done; returns negedge count, busy cycles
  // and acks seen. Optionally disturbs addr0/we0 every other cycle.
  task automatic wait_done(input logic r, input int budget, input logic toggle,
                           output int lat, output int busy_n, output int acks);
    logic got = 1'b0;
    lat = 0; busy_n = 0; acks = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (r ? word_ack1 : word_ack0) acks++;
      if (r ? done1 : done0) got = 1'b1;
      else if (toggle && (lat % 2 == 0)) begin
        addr0 = addr0 ^ 32'h0000_FFF0;
        we0   = ~we0;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout waiting for done%0d after %0d cycles", r, lat);
    end
  endtask

  // Monitor / scoreboard
  exp_t m_e;
  logic m_d;
  logic prev_req = 1'b0;
  logic seen_burst = 1'b0;
  int   low_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req   = 1'b0;
      seen_burst = 1'b0;
      low_cnt    = 0;
    end else begin
      if (word_ack0 || word_ack1) begin
        chk("ack_exclusive", {31'd0, word_ack0 & word_ack1}, 32'd0);
        chk("ack_needs_ready", {31'd0, mem_ready}, 32'd1);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got ack0=%b ack1=%b addr=%h expected none", word_ack0, word_ack1, mem_addr);
        end else begin
          m_e = exp_q.pop_front();
          chk("ack_owner", {31'd0, word_ack1}, {31'd0, m_e.r});
          chk("mem_we",    {31'd0, mem_we},    {31'd0, m_e.we});
          chk("mem_addr",  mem_addr,  m_e.addr);
          chk("mem_wdata", mem_wdata, m_e.wdata);
          chk("rdata",     rdata,     32'hA500_0000 ^ m_e.addr);
          chk("word_idx",  {29'd0, word_idx}, {29'd0, m_e.addr[4:2]});
        end
      end
      if (done0 || done1) begin
        chk("done_mem_req_low", {31'd0, mem_req}, 32'd0);
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done0=%b done1=%b expected none", done0, done1);
        end else begin
          m_d = done_q.pop_front();
          chk("done_owner", {30'd0, done1, done0}, m_d ? 32'd2 : 32'd1);
        end
      end
      if (mem_req && !prev_req && seen_burst)
        chk("gap_ge_2", {31'd0, (low_cnt >= 2)}, 32'd1);
      if (mem_req) begin
        seen_burst = 1'b1;
        low_cnt    = 0;
      end else begin
        low_cnt++;
      end
      prev_req = mem_req;
    end
  end

  int lat, bn, acks;
  logic found;

  initial begin
    // Reset state
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_acks", {30'd0, word_ack1, word_ack0}, 32'd0);
    chk("rst_word_idx", {29'd0, word_idx}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Read burst, zero wait
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_1234;
    push_burst(1'b1, 1'b0, 32'h0000_1220);
    wait_done(1'b1, 40, 1'b0, lat, bn, acks);
    req1 = 1'b0;
    chk("read_latency", 32'(lat), 32'd10);
    chk("read_busy_cycles", 32'(bn), 32'd9);
    chk("read_acks", 32'(acks), 32'd8);

    // Write-back with wait states
    rdy_mode = 1;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_0040;
    push_burst(1'b0, 1'b1, 32'h0000_0040);
    wait_done(1'b0, 100, 1'b0, lat, bn, acks);
    req0 = 1'b0;
    chk("wb_acks", 32'(acks), 32'd8);
    chk("wb_queue_drained", 32'(exp_q.size()), 32'd0);
    rdy_mode = 0;

    // Simultaneous requests after reset (last_grant=1): 0 then 1, twice
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0104;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_0218;
      push_burst(1'b0, 1'b0, 32'h0000_0100);
      push_burst(1'b1, 1'b0, 32'h0000_0200);
      wait_done(1'b0, 40, 1'b0, lat, bn, acks);
      req0 = 1'b0;
      wait_done(1'b1, 40, 1'b0, lat, bn, acks);
      req1 = 1'b0;
      chk("pair_second_latency", 32'(lat), 32'd10);
    end

    // Back-to-back from requester 1 with requester 0 raised mid-burst
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0000_0A00;
    push_burst(1'b1, 1'b1, 32'h0000_0A00);
    push_burst(1'b0, 1'b0, 32'h0000_0300);
    push_burst(1'b1, 1'b1, 32'h0000_0A00);
    repeat (3) @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0300;
    wait_done(1'b1, 40, 1'b0, lat, bn, acks);
    wait_done(1'b0, 40, 1'b0, lat, bn, acks);
    req0 = 1'b0;
    wait_done(1'b1, 40, 1'b0, lat, bn, acks);
    req1 = 1'b0;

    // Reset mid-burst at word 4
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_2000;
    push_burst(1'b1, 1'b0, 32'h0000_2000);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (word_ack1 && word_idx == 3'd4) found = 1'b1;
    end
    chk("reached_word4", {31'd0, found}, 32'd1);
    #1 rst = 1'b1; req1 = 1'b0;
    #1;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_ack", {30'd0, word_ack1, word_ack0}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {30'd0, done1, done0}, 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0000_2000;
    push_burst(1'b1, 1'b0, 32'h0000_2000);
    wait_done(1'b1, 40, 1'b0, lat, bn, acks);
    req1 = 1'b0;
    chk("post_rst_acks", 32'(acks), 32'd8);

    // Request inputs disturbed during BUSY
    rdy_mode = 1;
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0500;
    push_burst(1'b0, 1'b0, 32'h0000_0500);
    wait_done(1'b0, 100, 1'b1, lat, bn, acks);
    req0 = 1'b0; we0 = 1'b0;
    chk("toggle_acks", 32'(acks), 32'd8);
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one word-wide main-memory port between the instruction-side cache (requester 0) and the data-side cache (requester 1).
- Each granted request is a full cache-line burst: either a refill (read) or a write-back (write).
- Requesters are served round-robin, and each burst runs to completion without interruption.
- Sits between the two cache instances and the main-memory model. A cache keeps its miss signal high until it receives its done pulse.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; WORDS = 2^LINE_ADDR_LEN (8 by default).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 wants a burst
- we0  in  1  requester 0 burst is a write-back (1) or refill (0)
- addr0  in  32  requester 0 line byte address; bits [LINE_ADDR_LEN+1:0] are ignored
- wdata0  in  32  requester 0 write word for the current word_idx
- req1, we1, addr1, wdata1: same as above, for requester 1
- word_ack0  out  1  one memory word transferred for requester 0 this cycle
- word_ack1  out  1  one memory word transferred for requester 1 this cycle
- done0  out  1  one-cycle pulse: requester 0 burst finished
- done1  out  1  one-cycle pulse: requester 1 burst finished
- word_idx  out  LINE_ADDR_LEN  index of the word currently being transferred
- rdata  out  32  read word; valid when word_ack0 or word_ack1 is high
- busy  out  1  a burst is in progress (state BUSY or DONE)
- mem_req  out  1  memory access request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word byte address to memory
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  read data from memory
- mem_ready  in  1  memory completes the current word this cycle

Behaviour:
- States: IDLE, BUSY, DONE. Registers: state, owner, burst_we, base_addr, cnt, last_grant, done pulses.
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state=IDLE, owner=0, cnt=0, last_grant=1, base_addr=0.
  - All outputs 0: mem_req, word_ack0/1, done0/1, busy, word_idx, mem_addr, mem_wdata, mem_we.
  - Any burst in flight is abandoned; no done pulse is issued for it.
- IDLE, choosing a grant:
  - Only one req high: grant that requester.
  - Both high: grant the requester that is not last_grant.
  - On a grant: latch owner, burst_we, and base_addr = {addr[31:LINE_ADDR_LEN+2], zeros}; set cnt=0; go to BUSY.
  - req is sampled at cycle N; mem_req first goes high at cycle N+1.
- BUSY, each cycle:
  - mem_req=1, mem_we=burst_we, mem_addr = base_addr + (cnt<<2).
  - mem_wdata = wdata of the owner (combinational), word_idx = cnt.
  - When mem_ready=1:
    - word_ack of the owner = 1 for that cycle (combinational).
    - rdata = mem_rdata (passthrough; driven even on writes, consumers ignore it).
    - cnt increments.
  - When cnt == WORDS-1 and mem_ready=1: go to DONE and set last_grant=owner.
  - When mem_ready=0: all BUSY outputs hold unchanged.
- DONE: lasts exactly 1 cycle.
  - done of the owner = 1 (registered), mem_req=0, no new grant is made, then return to IDLE.
  - The requester drops req in the DONE cycle. Minimum gap between bursts is 2 cycles with mem_req low (DONE, then IDLE).
- Boundary conditions:
  - req or addr changing during BUSY is ignored; the latched values rule.
  - mem_ready while not in BUSY is ignored.
  - The non-owner's req stays pending and is granted from the next IDLE if still asserted.
  - cnt never wraps inside a burst.
  - base_addr addition does not carry into the ignored low bits; mem_addr[1:0] is always 00.
- Burst latency: WORDS + (sum of memory wait cycles) + 2 cycles from req to done.

Test Plan:
- Read burst, zero wait: req1=1, we1=0, addr1=0x00001234, mem_ready tied 1.
  - mem_addr steps 0x1220, 0x1224 … 0x123C over 8 cycles with word_ack1 each cycle.
  - done1 pulses at cycle 10 after req; busy is high for 9 cycles.
- Write-back with wait states: req0=1, we0=1, addr0=0x40, mem_ready high every 3rd cycle.
  - mem_we=1 throughout; mem_wdata tracks wdata0 at word_idx 0..7.
  - word_ack0 pulses exactly 8 times, only in mem_ready cycles; done0 follows the 8th ack.
- Simultaneous requests: req0=req1=1 after reset (last_grant=1).
  - Requester 0 is served first, then requester 1 after a 2-cycle gap.
  - Repeat the pair: order is 0 then 1 again, because last_grant=1 when both are next pending.
- Back-to-back from one requester: req1 held high, re-asserted right after done1, while req0 is raised mid-burst.
  - The next grant goes to 0 (round-robin), not 1.
- Reset mid-burst: assert rst at word 4 of a read.
  - mem_req, word_ack and busy go to 0 in the same cycle; no done is produced.
  - After release, a fresh req1 starts at word_idx 0.
- Request change during burst: toggle addr0 and we0 while BUSY.
  - mem_addr and mem_we are unaffected; exactly 8 words are transferred.
